seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_scan_driver_pkg.sv | 17 +
 rtl/seg7_scan_driver_hex_seg_decode.sv | 13 +
 rtl/seg7_scan_driver.sv | 152 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the multiplexed seven-segment scan driver:
// hex-to-segment code table and legal parameter ranges.
package seg7_scan_driver_pkg;

    localparam int unsigned MIN_DIGITS      = 1;
    localparam int unsigned MAX_DIGITS      = 8;
    localparam int unsigned MIN_SLOT_CYCLES = 2;

    // Active-low segment codes {g,f,e,d,c,b,a} for hex digits 0..F.
    localparam logic [6:0] SEG_CODES [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [6:0] SEG_ALL_OFF_N = 7'h7F;

endpackage

// File: rtl/seg7_scan_driver_hex_seg_decode.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_seg_decode
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_CODES[hex];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver with tear-free double-buffered
// loads, per-digit blanking, leading-zero suppression and polarity select.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned SLOT_CYCLES = 50000,
    parameter int unsigned ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lz_blank,
    input  logic                    load,
    output logic [6:0]              seg7,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int unsigned CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
    localparam logic [IW-1:0] DIG_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic POL_LOW = (ACTIVE_LOW != 0);

    localparam logic [6:0]            SEG_IDLE = POL_LOW ? '1 : '0;
    localparam logic                  DP_IDLE  = POL_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_IDLE  = POL_LOW ? '1 : '0;

    if (NUM_DIGITS < MIN_DIGITS || NUM_DIGITS > MAX_DIGITS ||
        SLOT_CYCLES < MIN_SLOT_CYCLES) begin : g_bad_params
        $error("seg7_scan_driver: NUM_DIGITS or SLOT_CYCLES out of range");
    end

    typedef enum logic {WARMUP, SCAN} out_phase_e;

    logic [CW-1:0]           slot_cnt;
    logic [IW-1:0]           digit;
    logic                    slot_wrap;
    logic                    frame_end;

    logic [4*NUM_DIGITS-1:0] disp_val,   pend_val;
    logic [NUM_DIGITS-1:0]   disp_dp,    pend_dp;
    logic [NUM_DIGITS-1:0]   disp_blank, pend_blank;
    logic                    pend_valid;
    out_phase_e              phase;

    logic [3:0]              cur_nib;
    logic                    cur_forced;
    logic                    cur_dp_bit;
    logic                    cur_hi_zero;
    logic                    cur_lz;
    logic                    cur_dp_on;
    logic [6:0]              dec_n;
    logic [6:0]              seg_next_n;
    logic [NUM_DIGITS-1:0]   an_next;

    assign slot_wrap  = (slot_cnt == SLOT_LAST);
    assign frame_end  = slot_wrap && (digit == DIG_LAST);
    assign frame_done = frame_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt <= '0;
            digit    <= '0;
        end else if (slot_wrap) begin
            slot_cnt <= '0;
            digit    <= (digit == DIG_LAST) ? '0 : digit + 1'b1;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    // A load on the frame boundary bypasses the pending buffer so it lands
    // in the very next frame; otherwise only the last pending load survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_val   <= '0;
            disp_dp    <= '0;
            disp_blank <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_valid <= 1'b0;
        end else if (frame_end) begin
            if (load) begin
                disp_val   <= value_in;
                disp_dp    <= dp_in;
                disp_blank <= blank_in;
            end else if (pend_valid) begin
                disp_val   <= pend_val;
                disp_dp    <= pend_dp;
                disp_blank <= pend_blank;
            end
            pend_valid <= 1'b0;
        end else if (load) begin
            pend_val   <= value_in;
            pend_dp    <= dp_in;
            pend_blank <= blank_in;
            pend_valid <= 1'b1;
        end
    end

    always_comb begin
        cur_nib     = '0;
        cur_forced  = 1'b0;
        cur_dp_bit  = 1'b0;
        cur_hi_zero = 1'b1;
        an_next     = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (32'(digit) == k) begin
                cur_nib    = disp_val[4*k +: 4];
                cur_forced = disp_blank[k];
                cur_dp_bit = disp_dp[k];
                an_next[k] = 1'b1;
            end
            if (k >= 32'(digit) && disp_val[4*k +: 4] != 4'h0) begin
                cur_hi_zero = 1'b0;
            end
        end
        cur_lz     = lz_blank && (digit != '0) && cur_hi_zero;
        cur_dp_on  = cur_dp_bit && !cur_forced;
        seg_next_n = (cur_forced || cur_lz) ? SEG_ALL_OFF_N : dec_n;
    end

    hex_seg_decode u_dec (
        .hex   (cur_nib),
        .seg_n (dec_n)
    );

    // Outputs stay dark for one edge after reset so the first lit anode
    // appears on the second edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= WARMUP;
            seg7  <= SEG_IDLE;
            dp    <= DP_IDLE;
            an    <= AN_IDLE;
        end else begin
            phase <= SCAN;
            if (phase == SCAN) begin
                seg7 <= POL_LOW ? seg_next_n : ~seg_next_n;
                dp   <= POL_LOW ? ~cur_dp_on : cur_dp_on;
                an   <= POL_LOW ? ~an_next   : an_next;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed scenarios plus random
// loads compared against a frame-level behavioural model.
module tb_seg7_scan_driver;

    localparam int N  = 4;
    localparam int S  = 4;
    localparam int FR = N * S;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value_in = '0;
    logic [3:0]  dp_in = '0, blank_in = '0;
    logic        lz_blank = 1'b0, load = 1'b0;
    logic [6:0]  seg7;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    logic [15:0] value2 = '0;
    logic [3:0]  dp2_in = '0, blank2_in = '0;
    logic        load2 = 1'b0;
    logic [6:0]  seg7_2;
    logic        dp_2;
    logic [3:0]  an_2;
    logic        frame_done_2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.NUM_DIGITS(4), .SLOT_CYCLES(4), .ACTIVE_LOW(1)) dut (
        .clk(clk), .rst(rst), .value_in(value_in), .dp_in(dp_in),
        .blank_in(blank_in), .lz_blank(lz_blank), .load(load),
        .seg7(seg7), .dp(dp), .an(an), .frame_done(frame_done)
    );

    seg7_scan_driver #(.NUM_DIGITS(4), .SLOT_CYCLES(4), .ACTIVE_LOW(0)) dut_hi (
        .clk(clk), .rst(rst), .value_in(value2), .dp_in(dp2_in),
        .blank_in(blank2_in), .lz_blank(1'b0), .load(load2),
        .seg7(seg7_2), .dp(dp_2), .an(an_2), .frame_done(frame_done_2)
    );

    // Behavioural reference: t counts clock edges since reset release.
    logic [6:0] segtab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    int          t;
    logic [15:0] m_val, p_val;
    logic [3:0]  m_dp, p_dp, m_bl, p_bl;
    logic        p_v;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_an;

    function automatic logic [6:0] ref_seg(int tt, logic [15:0] v, logic [3:0] bl, logic lz);
        int d = (tt / S) % N;
        logic [15:0] hi = v >> (4 * d);
        if (tt < 1) return 7'h7F;
        if (bl[d] || (lz && d > 0 && hi == 16'h0)) return 7'h7F;
        return segtab[hi[3:0]];
    endfunction

    function automatic logic ref_dp(int tt, logic [3:0] dpv, logic [3:0] bl);
        int d = (tt / S) % N;
        if (tt < 1) return 1'b1;
        return !(dpv[d] && !bl[d]);
    endfunction

    function automatic logic [3:0] ref_an(int tt);
        int d = (tt / S) % N;
        if (tt < 1) return 4'hF;
        return ~(4'b0001 << d);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t <= 0;
            m_val <= '0; m_dp <= '0; m_bl <= '0;
            p_val <= '0; p_dp <= '0; p_bl <= '0; p_v <= 1'b0;
            e_seg <= 7'h7F; e_dp <= 1'b1; e_an <= 4'hF;
        end else begin
            e_seg <= ref_seg(t, m_val, m_bl, lz_blank);
            e_dp  <= ref_dp(t, m_dp, m_bl);
            e_an  <= ref_an(t);
            if (t % FR == FR - 1) begin
                if (load) begin
                    m_val <= value_in; m_dp <= dp_in; m_bl <= blank_in;
                end else if (p_v) begin
                    m_val <= p_val; m_dp <= p_dp; m_bl <= p_bl;
                end
                p_v <= 1'b0;
            end else if (load) begin
                p_val <= value_in; p_dp <= dp_in; p_bl <= blank_in; p_v <= 1'b1;
            end
            t <= t + 1;
        end
    end

    // Returns at the first sample of a fresh frame's predecessor slot:
    // the next 16 negedges show digits 0..3 of the newly transferred data.
    task automatic sync_frame();
        int n = 0;
        @(negedge clk);
        while (frame_done !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            errors++; checks++;
            $display("FAIL sync_frame: frame_done got %b want 1", frame_done);
        end
        @(negedge clk);
    endtask

    task automatic do_load(logic [15:0] v, logic [3:0] d, logic [3:0] b);
        value_in = v; dp_in = d; blank_in = b; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks += 4;
        if (seg7 !== 7'h7F) begin errors++; $display("FAIL reset_seg7: got %h want 7f", seg7); end
        if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b want 1", dp); end
        if (an !== 4'hF) begin errors++; $display("FAIL reset_an: got %b want 1111", an); end
        if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b want 0", frame_done); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (an !== 4'hF) begin errors++; $display("FAIL first_edge_an: got %b want 1111", an); end
        @(negedge clk);
        checks += 3;
        if (an !== 4'b1110) begin errors++; $display("FAIL second_edge_an: got %b want 1110", an); end
        if (seg7 !== 7'h40) begin errors++; $display("FAIL second_edge_seg: got %h want 40", seg7); end
        if (an_2 !== 4'b0001) begin errors++; $display("FAIL second_edge_an_hi: got %b want 0001", an_2); end
    endtask

    task automatic test_scan_order();
        logic [6:0] want [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
        sync_frame();
        do_load(16'h1234, 4'h0, 4'h0);
        sync_frame();
        for (int i = 0; i < FR; i++) begin
            @(negedge clk);
            checks += 3;
            if (an !== ~(4'b0001 << (i / S))) begin errors++; $display("FAIL scan_an[%0d]: got %b want %b", i, an, ~(4'b0001 << (i / S))); end
            if (seg7 !== want[i / S]) begin errors++; $display("FAIL scan_seg[%0d]: got %h want %h", i, seg7, want[i / S]); end
            if (dp !== 1'b1) begin errors++; $display("FAIL scan_dp[%0d]: got %b want 1", i, dp); end
        end
    endtask

    task automatic test_lz_blank();
        lz_blank = 1'b1;
        sync_frame();
        do_load(16'h0007, 4'h0, 4'h0);
        sync_frame();
        for (int i = 0; i < FR; i++) begin
            @(negedge clk);
            checks++;
            if (seg7 !== ((i / S == 0) ? 7'h78 : 7'h7F)) begin errors++; $display("FAIL lz7_seg[%0d]: got %h want %h", i, seg7, (i / S == 0) ? 7'h78 : 7'h7F); end
        end
        sync_frame();
        do_load(16'h0000, 4'h0, 4'h0);
        sync_frame();
        for (int i = 0; i < FR; i++) begin
            @(negedge clk);
            checks += 2;
            if (seg7 !== ((i / S == 0) ? 7'h40 : 7'h7F)) begin errors++; $display("FAIL lz0_seg[%0d]: got %h want %h", i, seg7, (i / S == 0) ? 7'h40 : 7'h7F); end
            if (an !== ~(4'b0001 << (i / S))) begin errors++; $display("FAIL lz0_an[%0d]: got %b want %b", i, an, ~(4'b0001 << (i / S))); end
        end
        lz_blank = 1'b0;
    endtask

    task automatic test_last_wins();
        sync_frame();
        do_load(16'hAAAA, 4'h0, 4'h0);
        do_load(16'h5555, 4'h0, 4'h0);
        sync_frame();
        for (int i = 0; i < FR; i++) begin
            @(negedge clk);
            checks++;
            if (seg7 !== 7'h12) begin errors++; $display("FAIL last_wins_seg[%0d]: got %h want 12", i, seg7); end
        end
    endtask

    task automatic test_load_on_frame_done();
        logic [6:0] want [4] = '{7'h0E, 7'h40, 7'h46, 7'h10};
        int n = 0;
        @(negedge clk);
        while (frame_done !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 64) begin errors++; $display("FAIL fd_wait: frame_done got %b want 1", frame_done); end
        value_in = 16'h9C0F; dp_in = 4'h0; blank_in = 4'h0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < FR; i++) begin
            @(negedge clk);
            checks++;
            if (seg7 !== want[i / S]) begin errors++; $display("FAIL load_on_fd_seg[%0d]: got %h want %h", i, seg7, want[i / S]); end
        end
    endtask

    task automatic test_reset_midframe();
        sync_frame();
        do_load(16'hBEEF, 4'hF, 4'h0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks += 3;
        if (seg7 !== 7'h7F) begin errors++; $display("FAIL midrst_seg: got %h want 7f", seg7); end
        if (dp !== 1'b1) begin errors++; $display("FAIL midrst_dp: got %b want 1", dp); end
        if (an !== 4'hF) begin errors++; $display("FAIL midrst_an: got %b want 1111", an); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2 * FR; i++) begin
            @(negedge clk);
            checks += 3;
            if ($countones(~an) != 1) begin errors++; $display("FAIL midrst_onehot[%0d]: got %b want one-hot low", i, an); end
            if (seg7 !== 7'h40) begin errors++; $display("FAIL midrst_zero_seg[%0d]: got %h want 40", i, seg7); end
            if (dp !== 1'b1) begin errors++; $display("FAIL midrst_zero_dp[%0d]: got %b want 1", i, dp); end
        end
    endtask

    task automatic test_active_high();
        sync_frame();
        value2 = 16'h8888; dp2_in = 4'b0011; blank2_in = 4'b0010; load2 = 1'b1;
        @(negedge clk);
        load2 = 1'b0;
        sync_frame();
        for (int i = 0; i < FR; i++) begin
            int d = i / S;
            @(negedge clk);
            checks += 3;
            if (an_2 !== (4'b0001 << d)) begin errors++; $display("FAIL hi_an[%0d]: got %b want %b", i, an_2, 4'b0001 << d); end
            if (seg7_2 !== ((d == 1) ? 7'h00 : 7'h7F)) begin errors++; $display("FAIL hi_seg[%0d]: got %h want %h", i, seg7_2, (d == 1) ? 7'h00 : 7'h7F); end
            if (dp_2 !== (d == 0)) begin errors++; $display("FAIL hi_dp[%0d]: got %b want %b", i, dp_2, d == 0); end
        end
    endtask

    task automatic test_random();
        logic [15:0] masks [4] = '{16'h000F, 16'h00FF, 16'h0FFF, 16'hFFFF};
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            checks += 4;
            if (seg7 !== e_seg) begin errors++; $display("FAIL rnd_seg[%0d]: got %h want %h", i, seg7, e_seg); end
            if (dp !== e_dp) begin errors++; $display("FAIL rnd_dp[%0d]: got %b want %b", i, dp, e_dp); end
            if (an !== e_an) begin errors++; $display("FAIL rnd_an[%0d]: got %b want %b", i, an, e_an); end
            if (frame_done !== (!rst && (t % FR == FR - 1))) begin errors++; $display("FAIL rnd_fd[%0d]: got %b want %b", i, frame_done, !rst && (t % FR == FR - 1)); end
            load     = ($urandom_range(0, 5) == 0);
            value_in = 16'($urandom) & masks[$urandom_range(0, 3)];
            dp_in    = 4'($urandom);
            blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 15) == 0) lz_blank = ~lz_blank;
            if (i == 400) begin
                #2 rst = 1'b1;
                #1;
                checks++;
                if (seg7 !== 7'h7F || an !== 4'hF) begin errors++; $display("FAIL rnd_rst: got seg %h an %b want 7f 1111", seg7, an); end
                @(negedge clk);
                rst = 1'b0;
            end
        end
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_lz_blank();
        test_last_wins();
        test_load_on_frame_done();
        test_reset_midframe();
        test_active_high();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
